// File: rtl/im_loader_pkg.sv
// Shared state encoding and width helpers for the instruction-memory loader.
package im_loader_pkg;

    typedef enum logic [2:0] {
        COUNT,
        RECV,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    function automatic int bytes_per_word(input int instr_w);
        return (instr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// MSB-first byte-to-word assembler used by im_loader.
module byte_assembler
    import im_loader_pkg::*;
#(
    parameter int INSTR_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);
    localparam int BPW   = bytes_per_word(INSTR_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [INSTR_W-1:0] word_reg;
    logic [CNT_W-1:0]   byte_cnt;

    // word_full marks the accepted byte that completes the current word
    assign word_full = shift_en && (byte_cnt == LAST);
    assign word      = word_reg;

    // Bits shifted past INSTR_W fall off the top, discarding the unused MSBs of the first byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg <= '0;
            byte_cnt <= '0;
        end else begin
            if (shift_en) begin
                word_reg <= INSTR_W'({word_reg, byte_in});
            end
            if (clear) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                byte_cnt <= (byte_cnt == LAST) ? '0 : byte_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot loader: streams a program into instruction memory and holds the CPU in reset until loaded.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int INSTR_W = 15,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               load_req,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               err
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WCNT_W = ADDR_W + 1;

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              word_full;
    logic              last_word;
    logic [ADDR_W-1:0] addr;
    logic [WCNT_W-1:0] words_left;
    logic              ready_d;
    logic              we_d;
    logic              cpu_reset_d;
    logic              done_d;
    logic              err_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = in_valid && in_ready;
    assign last_word = (words_left == WCNT_W'(1));
    assign im_addr   = addr;

    byte_assembler #(
        .INSTR_W(INSTR_W)
    ) u_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept && (state == COUNT)),
        .shift_en (accept && (state == RECV)),
        .byte_in  (in_data),
        .word     (im_wdata),
        .word_full(word_full)
    );

    // Outputs are registered from next_state so each one changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COUNT;
            in_ready  <= 1'b1;
            im_we     <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= ready_d;
            im_we     <= we_d;
            cpu_reset <= cpu_reset_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COUNT: begin
                if (accept) begin
                    next_state = (int'(in_data) > DEPTH) ? ERROR : RECV;
                end
            end
            RECV: begin
                if (word_full) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (!last_word) begin
                    next_state = RECV;
                end else begin
`ifdef IM_LOADER_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    next_state = (in_data == csum) ? DONE : ERROR;
                end
            end
`endif
            DONE, ERROR: begin
                if (load_req) begin
                    next_state = COUNT;
                end
            end
            default: next_state = COUNT;
        endcase
    end

    always_comb begin
        ready_d     = (next_state == COUNT) || (next_state == RECV) || (next_state == CHECK);
        we_d        = (next_state == WRITE);
        cpu_reset_d = (next_state != DONE);
        done_d      = (next_state == DONE);
        err_d       = (next_state == ERROR);
    end

    // A count of 0 means a full memory; the address wraps naturally after the last slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            words_left <= '0;
        end else if (accept && (state == COUNT)) begin
            addr       <= '0;
            words_left <= (in_data == 8'd0) ? WCNT_W'(DEPTH) : WCNT_W'(in_data);
        end else if (state == WRITE) begin
            addr       <= addr + ADDR_W'(1);
            words_left <= words_left - WCNT_W'(1);
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (accept && (state == COUNT)) begin
            csum <= in_data;
        end else if (accept && (state == RECV)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule
